// File: rtl/hilo_seq_ctrl.sv
// hilo_seq_ctrl
//   Sequencer for the multiply/divide unit and the HI/LO write path.
//   Accepts mult/div requests in IDLE, pulses the selected unit's start,
//   waits for its done (bounded by TIMEOUT cycles), then issues a
//   one-cycle HI/LO write. Divide-by-zero is rejected in IDLE with an
//   exception pulse. MFHI/MFLO are stalled while an operation is in flight.
//
// Ports
//   clk          : clock, rising edge
//   reset        : asynchronous, active-low reset
//   op_mult      : MULT/MULTU request (sampled in IDLE only)
//   op_div       : DIV/DIVU request (sampled in IDLE only, op_mult wins)
//   divisor_zero : divisor operand is zero (sampled with op_div)
//   mfhilo_req   : control is executing MFHI/MFLO
//   mult_done    : multiplier result valid (level or pulse)
//   div_done     : divider result valid (level or pulse)
//   mult_go      : one-cycle multiplier start
//   div_go       : one-cycle divider start
//   src_sel      : Low/High mux select, 0 = multiplier, 1 = divider
//   hilo_we      : one-cycle HI/LO write enable
//   busy         : high in every non-IDLE state
//   stall        : mfhilo_req & busy (combinational)
//   div0_exc     : one-cycle divide-by-zero pulse
//   md_timeout   : one-cycle timeout/abort pulse
module hilo_seq_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic op_mult,
  input  logic op_div,
  input  logic divisor_zero,
  input  logic mfhilo_req,
  input  logic mult_done,
  input  logic div_done,
  output logic mult_go,
  output logic div_go,
  output logic src_sel,
  output logic hilo_we,
  output logic busy,
  output logic stall,
  output logic div0_exc,
  output logic md_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    MULT_RUN,
    DIV_RUN,
    WRITE
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic       mult_go_n, div_go_n, src_sel_n, hilo_we_n;
  logic       busy_n, div0_exc_n, md_timeout_n;
  logic       run_done;

  // Only the done of the unit actually running is observed.
  assign run_done = (state == MULT_RUN) ? mult_done : div_done;

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    src_sel_n    = src_sel;
    mult_go_n    = 1'b0;
    div_go_n     = 1'b0;
    hilo_we_n    = 1'b0;
    div0_exc_n   = 1'b0;
    md_timeout_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (op_mult) begin
          state_n   = MULT_RUN;
          mult_go_n = 1'b1;
          src_sel_n = 1'b0;
          cnt_n     = '0;
        end else if (op_div) begin
          if (divisor_zero) begin
            div0_exc_n = 1'b1;
          end else begin
            state_n   = DIV_RUN;
            div_go_n  = 1'b1;
            src_sel_n = 1'b1;
            cnt_n     = '0;
          end
        end
      end
      MULT_RUN, DIV_RUN: begin
        if (run_done) begin
          state_n   = WRITE;
          hilo_we_n = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_n      = IDLE;
          md_timeout_n = 1'b1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      WRITE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    // Registered busy is derived from the next state so it tracks state exactly.
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      mult_go    <= 1'b0;
      div_go     <= 1'b0;
      src_sel    <= 1'b0;
      hilo_we    <= 1'b0;
      busy       <= 1'b0;
      div0_exc   <= 1'b0;
      md_timeout <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      mult_go    <= mult_go_n;
      div_go     <= div_go_n;
      src_sel    <= src_sel_n;
      hilo_we    <= hilo_we_n;
      busy       <= busy_n;
      div0_exc   <= div0_exc_n;
      md_timeout <= md_timeout_n;
    end
  end

  assign stall = mfhilo_req & busy;

endmodule

// File: tb/tb_hilo_seq_ctrl.sv
// tb_hilo_seq_ctrl
//   Drives two instances (default TIMEOUT and TIMEOUT=8) with the same
//   stimulus and compares both against a behavioural model of the sequencer.
module tb_hilo_seq_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic op_mult = 1'b0, op_div = 1'b0, divisor_zero = 1'b0, mfhilo_req = 1'b0;
  logic mult_done = 1'b0, div_done = 1'b0;

  logic mult_go0, div_go0, src_sel0, hilo_we0, busy0, stall0, div0_exc0, md_timeout0;
  logic mult_go1, div_go1, src_sel1, hilo_we1, busy1, stall1, div0_exc1, md_timeout1;

  hilo_seq_ctrl dut64 (
    .clk(clk), .reset(reset), .op_mult(op_mult), .op_div(op_div),
    .divisor_zero(divisor_zero), .mfhilo_req(mfhilo_req),
    .mult_done(mult_done), .div_done(div_done),
    .mult_go(mult_go0), .div_go(div_go0), .src_sel(src_sel0), .hilo_we(hilo_we0),
    .busy(busy0), .stall(stall0), .div0_exc(div0_exc0), .md_timeout(md_timeout0)
  );

  hilo_seq_ctrl #(.TIMEOUT(8)) dut8 (
    .clk(clk), .reset(reset), .op_mult(op_mult), .op_div(op_div),
    .divisor_zero(divisor_zero), .mfhilo_req(mfhilo_req),
    .mult_done(mult_done), .div_done(div_done),
    .mult_go(mult_go1), .div_go(div_go1), .src_sel(src_sel1), .hilo_we(hilo_we1),
    .busy(busy1), .stall(stall1), .div0_exc(div0_exc1), .md_timeout(md_timeout1)
  );

  always #5 clk = ~clk;

  // Output vector order: {mult_go, div_go, src_sel, hilo_we, busy, div0_exc, md_timeout}
  logic [6:0] outs [2];
  logic       stalls [2];
  assign outs[0]   = {mult_go0, div_go0, src_sel0, hilo_we0, busy0, div0_exc0, md_timeout0};
  assign outs[1]   = {mult_go1, div_go1, src_sel1, hilo_we1, busy1, div0_exc1, md_timeout1};
  assign stalls[0] = stall0;
  assign stalls[1] = stall1;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: an operation is "in flight" for some number of edges
  // (age), then either writes once or aborts when age reaches the limit.
  int unsigned limit [2] = '{64, 8};
  bit          in_flight [2];
  bit          writing [2];
  bit          unit_div [2];
  int unsigned age [2];
  bit          m_src [2];
  logic [6:0]  exp_outs [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      in_flight[i] = 0;
      writing[i]   = 0;
      unit_div[i]  = 0;
      age[i]       = 0;
      m_src[i]     = 0;
      exp_outs[i]  = '0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit go_m, go_d, we, d0, to, done;
      go_m = 0; go_d = 0; we = 0; d0 = 0; to = 0;
      if (!reset) begin
        in_flight[i] = 0; writing[i] = 0; m_src[i] = 0;
      end else if (writing[i]) begin
        writing[i] = 0;
      end else if (in_flight[i]) begin
        age[i]++;
        done = unit_div[i] ? div_done : mult_done;
        if (done) begin
          in_flight[i] = 0; writing[i] = 1; we = 1;
        end else if (age[i] == limit[i]) begin
          in_flight[i] = 0; to = 1;
        end
      end else if (op_mult) begin
        in_flight[i] = 1; unit_div[i] = 0; age[i] = 0; m_src[i] = 0; go_m = 1;
      end else if (op_div) begin
        if (divisor_zero) d0 = 1;
        else begin
          in_flight[i] = 1; unit_div[i] = 1; age[i] = 0; m_src[i] = 1; go_d = 1;
        end
      end
      exp_outs[i] = {go_m, go_d, m_src[i], we, in_flight[i] | writing[i], d0, to};
    end
  endtask

  task automatic check_outs(input string tag);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (outs[i] !== exp_outs[i]) begin
        n_bad++;
        $display("FAIL %s inst%0d outs{go_m,go_d,src,we,busy,d0,to} got %b expected %b at %0t",
                 tag, i, outs[i], exp_outs[i], $time);
      end
    end
  endtask

  task automatic check_stall(input string tag);
    for (int i = 0; i < 2; i++) begin
      logic e;
      e = mfhilo_req & exp_outs[i][2];
      n_cmp++;
      if (stalls[i] !== e) begin
        n_bad++;
        $display("FAIL %s inst%0d stall got %b expected %b at %0t", tag, i, stalls[i], e, $time);
      end
    end
  endtask

  // One clock: check stall with settled inputs, advance model, compare after edge.
  task automatic cycle(input string tag);
    #1;
    check_stall(tag);
    model_edge();
    @(posedge clk);
    #1;
    check_outs(tag);
  endtask

  task automatic clear_inputs();
    op_mult = 0; op_div = 0; divisor_zero = 0; mfhilo_req = 0;
    mult_done = 0; div_done = 0;
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int k = 0; k < n; k++) cycle(tag);
  endtask

  task automatic test_reset();
    @(posedge clk);
    #2 reset = 0;
    #1;
    model_reset();
    check_outs("reset_async");
    mfhilo_req = 1;
    idle_cycles(2, "reset_held");
    #3 reset = 1;
    mfhilo_req = 0;
    idle_cycles(2, "reset_release");
  endtask

  task automatic test_mult();
    op_mult = 1;
    cycle("mult_start");
    op_mult = 0;
    idle_cycles(4, "mult_run");
    mult_done = 1;
    cycle("mult_done");
    mult_done = 0;
    idle_cycles(3, "mult_tail");
  endtask

  task automatic test_div();
    op_div = 1;
    cycle("div_start");
    op_div = 0;
    for (int k = 0; k < 33; k++) begin
      mult_done = (k == 3 || k == 4);
      cycle("div_run");
    end
    mult_done = 0;
    div_done = 1;
    cycle("div_done");
    div_done = 0;
    idle_cycles(3, "div_tail");
  endtask

  task automatic test_div0();
    op_div = 1; divisor_zero = 1;
    cycle("div0");
    clear_inputs();
    idle_cycles(2, "div0_tail");
  endtask

  task automatic test_stall_priority();
    mfhilo_req = 1;
    op_mult = 1; op_div = 1;
    cycle("prio_start");
    op_mult = 0; op_div = 0;
    idle_cycles(2, "stall_run");
    mult_done = 1;
    cycle("stall_done");
    mult_done = 0;
    idle_cycles(3, "stall_tail");
    mfhilo_req = 0;
  endtask

  task automatic test_timeout();
    op_mult = 1;
    cycle("to_start");
    op_mult = 0;
    for (int k = 1; k <= 14; k++) begin
      mult_done = (k == 10);
      cycle("to_run");
    end
    clear_inputs();
    idle_cycles(55, "to_long");
  endtask

  task automatic test_reset_mid();
    op_div = 1;
    cycle("rmid_start");
    op_div = 0;
    idle_cycles(4, "rmid_run");
    #3 reset = 0;
    #1;
    model_reset();
    check_outs("rmid_async");
    #2 reset = 1;
    div_done = 1;
    idle_cycles(3, "rmid_late_done");
    div_done = 0;
    idle_cycles(2, "rmid_tail");
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      op_mult      = ($urandom_range(0, 5) == 0);
      op_div       = ($urandom_range(0, 4) == 0);
      divisor_zero = ($urandom_range(0, 3) == 0);
      mfhilo_req   = $urandom_range(0, 1);
      mult_done    = ($urandom_range(0, 9) == 0);
      div_done     = ($urandom_range(0, 11) == 0);
      cycle("random");
    end
    clear_inputs();
    idle_cycles(3, "random_tail");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_mult();
    test_div();
    test_div0();
    test_stall_priority();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
